functional_unit_pipe: RTL
=========================

// Module: functional_unit_pipe
// PURPOSE
//  Parametrised, pipelined successor of functional_unit: ALU, shifter, MADD and select paths
//  share one result/flag datapath, followed by a STAGES-deep register pipeline.
//  Valid/ready handshakes on the input and output sides let the unit sit between an issue
//  stage and a writeback stage that can stall. One op is accepted per cycle; there are no bubbles.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of two)
//  STAGES  2   result latency in cycles, 1..4 (number of pipeline register ranks)
// PORTS
//  CLOCK      in   1      single clock; all state updates on the rising edge
//  RESET      in   1      synchronous, active-high reset
//  A,B,C      in   WIDTH  operands; B[log2(WIDTH)-1:0] is the shift amount
//  INST       in   6      opcode (see BEHAVIOUR)
//  IN_VALID   in   1      operands/opcode present this cycle
//  IN_READY   out  1      unit accepts the op this cycle
//  Z          out  WIDTH  result
//  FLAGS      out  4      {N,ZF,CY,V}
//  OUT_VALID  out  1      Z/FLAGS hold a valid result
//  OUT_READY  in   1      consumer accepts the result this cycle
// BEHAVIOUR
//  Ops (INST): ADD 000010 A+B; SUB 000011 A-B; AND 001000; OR 001001; XOR 001010; NOTA 001101 ~A;
//   LT 001110 signed A<B ->1/0; EQ 011110 A==B ->1/0; SHR 100000 logical; SHL 100011;
//   ASHR 100101; MUL 1110xx low WIDTH of A*B; MADD 1111xx low WIDTH of A*B+C;
//   SELECT 110000 C[0]?A:B. Any other code: Z=0, FLAGS=0000, still handshaked.
//  Flags: N=Z[WIDTH-1]; ZF=(Z==0); CY=carry out for ADD/MADD, no-borrow (A>=B unsigned) for SUB,
//   0 otherwise; V=signed overflow for ADD/SUB, 0 otherwise. All flags derive from the final Z.
//  Pipeline: result/flags are computed combinationally from inputs, then pass through STAGES
//   register ranks, each carrying {valid,Z,FLAGS}.
//  Advance: adv = ~OUT_VALID | OUT_READY; IN_READY = adv (combinational, no dependency on IN_VALID).
//   On adv, every rank shifts by one; rank0 loads {IN_VALID,result,flags}. When adv=0 the whole
//   pipe holds and Z/FLAGS/OUT_VALID stay stable.
//  Latency: an op accepted at edge k is visible on OUT_VALID/Z after edge k+STAGES-1, provided
//   no stall occurs in between. Throughput is 1 op/cycle when OUT_READY is held at 1.
//  Transfer: input when IN_VALID&IN_READY; output when OUT_VALID&OUT_READY. Data under a
//   deasserted valid is don't-care in the pipe, but Z/FLAGS are forced to 0 when OUT_VALID=0.
//  Ordering: strictly in order; no op is dropped or duplicated under any stall pattern.
//  Reset: all valid bits 0, Z=0, FLAGS=0, OUT_VALID=0. IN_READY=1 from the first cycle after
//   reset. Ops in flight when RESET asserts are discarded. With RESET and IN_VALID both high,
//   the op is not accepted.
//  Widths: intermediate sums are WIDTH+1 bits and the product is 2*WIDTH bits; results are
//   truncated to WIDTH. A shift amount >= WIDTH cannot occur because only log2(WIDTH) bits are used.
// CONFIGURATION
//  FU_SATURATE_EN defined: ADD/SUB clamp to the signed max/min on signed overflow; V is still set;
//   N/ZF follow the clamped Z; CY is unchanged.
//  FU_SATURATE_EN undefined: ADD/SUB wrap modulo 2^WIDTH; no saturation logic is built.
// TESTING (WIDTH=32, STAGES=2 unless noted)
//  1 ADD A=7FFFFFFF B=1, OUT_READY=1 -> Z=80000000, FLAGS=1001 two edges after accept;
//    with FU_SATURATE_EN: Z=7FFFFFFF, FLAGS=0001.
//  2 SUB A=5 B=5 -> Z=0, FLAGS=0110; LT A=FFFFFFFF B=1 -> Z=1, FLAGS=0000;
//    MADD A=3 B=4 C=FFFFFFF4 -> Z=0, FLAGS=0110.
//  3 Back-to-back SHL/SHR/ASHR with A=80000001 B=1, OUT_READY=1 -> Z=00000002, 40000000,
//    C0000000 on consecutive cycles; IN_READY stays 1.
//  4 Stream 6 ops, OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0 while OUT_VALID=1;
//    Z/FLAGS stable; all 6 results delivered in order, none lost or duplicated.
//  5 RESET asserted with 2 ops in flight -> next cycle OUT_VALID=0, Z=0, FLAGS=0, IN_READY=1;
//    no stale result appears later.
//  6 Repeat tests 3-4 with STAGES=1 and STAGES=4, and WIDTH=16 -> latency equals STAGES;
//    same ordering guarantees; plus a random-op scoreboard against a reference model.

Source files
------------

// File: rtl/functional_unit_pipe_if.sv
// Operand/result handshake bundle for functional_unit_pipe.
//   master : issue/writeback side (drives operands, opcode, in_valid, out_ready)
//   slave  : the functional unit (drives in_ready, z, flags, out_valid)
// Signals: a, b, c [WIDTH], inst [6], in_valid, in_ready, z [WIDTH],
//          flags [4] = {n, zf, cy, v}, out_valid, out_ready.
interface functional_unit_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [5:0]       inst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] z;
    logic [3:0]       flags;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, c, inst, in_valid, out_ready,
        input  in_ready, z, flags, out_valid
    );

    modport slave (
        input  a, b, c, inst, in_valid, out_ready,
        output in_ready, z, flags, out_valid
    );
endinterface

// File: rtl/functional_unit_pipe.sv
// Pipelined functional unit: ALU, shifter, multiply/MADD and select share one
// combinational result/flag path feeding a STAGES-deep register pipeline with
// valid/ready flow control on both sides.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   fu   - functional_unit_pipe_if.slave: operands/opcode in, z/flags out
// Parameters: WIDTH (>=8, power of two), STAGES (1..4).
// Build option: define FU_SATURATE_EN to clamp ADD/SUB to the signed max/min on
// signed overflow; without it ADD/SUB wrap.
module functional_unit_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    functional_unit_pipe_if.slave fu
);

    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   dif_c;
    logic [WIDTH:0]   madd_c;
    logic [WIDTH-1:0] prod_lo_c;
    logic [SHW-1:0]   sh_c;
    logic [WIDTH-1:0] res_c;
    logic             cy_c;
    logic             v_c;
    logic             op_ok_c;
    logic [3:0]       flg_c;
    logic             adv_c;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  z_q   [STAGES];
    logic [WIDTH-1:0]  z_d   [STAGES];
    logic [3:0]        flg_q [STAGES];
    logic [3:0]        flg_d [STAGES];

    // Result and flag computation for the op currently presented
    always_comb begin : alu
        sh_c      = fu.b[SHW-1:0];
        sum_c     = {1'b0, fu.a} + {1'b0, fu.b};
        dif_c     = {1'b0, fu.a} - {1'b0, fu.b};
        // Only the low half of the 2*WIDTH product ever reaches z
        prod_lo_c = fu.a * fu.b;
        madd_c    = {1'b0, prod_lo_c} + {1'b0, fu.c};
        res_c     = '0;
        cy_c      = 1'b0;
        v_c       = 1'b0;
        op_ok_c   = 1'b1;
        casez (fu.inst)
            6'b000010: begin
                res_c = sum_c[WIDTH-1:0];
                cy_c  = sum_c[WIDTH];
                v_c   = (fu.a[WIDTH-1] == fu.b[WIDTH-1]) && (sum_c[WIDTH-1] != fu.a[WIDTH-1]);
            end
            6'b000011: begin
                res_c = dif_c[WIDTH-1:0];
                cy_c  = ~dif_c[WIDTH];   // no borrow means a >= b unsigned
                v_c   = (fu.a[WIDTH-1] != fu.b[WIDTH-1]) && (dif_c[WIDTH-1] != fu.a[WIDTH-1]);
            end
            6'b001000: res_c = fu.a & fu.b;
            6'b001001: res_c = fu.a | fu.b;
            6'b001010: res_c = fu.a ^ fu.b;
            6'b001101: res_c = ~fu.a;
            6'b001110: res_c = WIDTH'($signed(fu.a) < $signed(fu.b));
            6'b011110: res_c = WIDTH'(fu.a == fu.b);
            6'b100000: res_c = fu.a >> sh_c;
            6'b100011: res_c = fu.a << sh_c;
            6'b100101: res_c = $unsigned($signed(fu.a) >>> sh_c);
            6'b1110??: res_c = prod_lo_c;
            6'b1111??: begin
                res_c = madd_c[WIDTH-1:0];
                cy_c  = madd_c[WIDTH];
            end
            6'b110000: res_c = fu.c[0] ? fu.a : fu.b;
            default:   op_ok_c = 1'b0;
        endcase
`ifdef FU_SATURATE_EN
        // Overflow direction follows the sign of a for both ADD and SUB
        if (v_c) begin
            res_c = fu.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flg_c = op_ok_c ? {res_c[WIDTH-1], (res_c == '0), cy_c, v_c} : 4'b0000;
    end

    // Whole pipe advances unless the output rank holds an unconsumed result
    assign adv_c       = ~vld_q[STAGES-1] | fu.out_ready;
    assign fu.in_ready = adv_c;

    // Next-state of the rank chain; payload is zeroed under a cleared valid so
    // the output rank reads 0 whenever out_valid is low
    always_comb begin : pipe_next
        vld_d = vld_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            z_d[i]   = z_q[i];
            flg_d[i] = flg_q[i];
        end
        if (adv_c) begin
            for (int i = int'(STAGES) - 1; i > 0; i--) begin
                vld_d[i] = vld_q[i-1];
                z_d[i]   = z_q[i-1];
                flg_d[i] = flg_q[i-1];
            end
            vld_d[0] = fu.in_valid;
            z_d[0]   = fu.in_valid ? res_c : '0;
            flg_d[0] = fu.in_valid ? flg_c : 4'b0000;
        end
    end

    // Rank registers
    always_ff @(posedge clk) begin : pipe_regs
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                z_q[i]   <= '0;
                flg_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            z_q   <= z_d;
            flg_q <= flg_d;
        end
    end

    assign fu.out_valid = vld_q[STAGES-1];
    assign fu.z         = z_q[STAGES-1];
    assign fu.flags     = flg_q[STAGES-1];

endmodule
